// File: rtl/avalon_wait_injector.sv
// Wait-state injector between an Avalon-style master and a single-cycle RAM: W = fixed or LFSR-derived.
// Latency W+2 cycles from first request to completion; waitrequest stalls the master until COMPLETE.
module avalon_wait_injector #(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 32,
    parameter int         READ_WAIT   = 2,
    parameter int         WRITE_WAIT  = 3,
    parameter int         RANDOM_MODE = 0,
    parameter int         MAX_WAIT    = 7,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_writedata,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    input  logic [DATA_WIDTH-1:0]   mem_readdata,
    output logic                    protocol_error,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count,
    output logic [31:0]             stall_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_COMPLETE
    } state_t;

    localparam logic [7:0] RD_WAIT    = 8'(READ_WAIT);
    localparam logic [7:0] WR_WAIT    = 8'(WRITE_WAIT);
    localparam logic [8:0] RAND_RANGE = 9'(MAX_WAIT + 1);

    state_t                  state;
    logic [7:0]              wait_cnt;
    logic [7:0]              lfsr;
    logic                    req_rd;
    logic                    req_wr;
    logic [DATA_WIDTH-1:0]   readdata_q;

    logic                    req;
    logic                    req_changed;
    logic                    lfsr_fb;
    logic [7:0]              lfsr_next;
    logic [7:0]              wait_load;

    assign req         = read | write;
    assign waitrequest = req && (state != S_COMPLETE);

    // Read data is forwarded straight from the RAM in the completion cycle, then held.
    assign readdata = (state == S_COMPLETE && req_rd) ? mem_readdata : readdata_q;

    // Any change to the request signature while it is stalled breaks the Avalon hold rule.
    assign req_changed = (read != req_rd) || (write != req_wr) || (address != mem_address);

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lfsr_next = {lfsr[6:0], lfsr_fb};

    always_comb begin
        wait_load = WR_WAIT;
        if (RANDOM_MODE != 0) begin
            wait_load = 8'({1'b0, lfsr} % RAND_RANGE);
        end else if (read) begin
            wait_load = RD_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            lfsr           <= LFSR_SEED;
            req_rd         <= 1'b0;
            req_wr         <= 1'b0;
            readdata_q     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            protocol_error <= 1'b0;
            read_count     <= '0;
            write_count    <= '0;
            stall_count    <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (waitrequest) begin
                stall_count <= stall_count + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        mem_address    <= address;
                        mem_writedata  <= writedata;
                        mem_byteenable <= byteenable;
                        req_rd         <= read;
                        req_wr         <= write;
                        wait_cnt       <= wait_load;
                        lfsr           <= lfsr_next;
                        if (read && write) begin
                            protocol_error <= 1'b1;
                        end
                        if (wait_load == 8'd0) begin
                            state     <= S_ISSUE;
                            mem_read  <= read;
                            mem_write <= ~read;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (req_changed) begin
                        protocol_error <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                        if (wait_cnt == 8'd1) begin
                            state     <= S_ISSUE;
                            mem_read  <= req_rd;
                            mem_write <= ~req_rd;
                        end
                    end
                end

                // The strobe is already on the RAM bus this cycle; a violation only skips completion.
                S_ISSUE: begin
                    if (req_changed) begin
                        protocol_error <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        state <= S_COMPLETE;
                    end
                end

                S_COMPLETE: begin
                    if (req_rd) begin
                        readdata_q <= mem_readdata;
                        read_count <= read_count + 32'd1;
                    end else begin
                        write_count <= write_count + 32'd1;
                    end
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_wait_injector.sv
// Three injector variants share one master bus; sel picks the instance under test and the RAM source.
module tb_avalon_wait_injector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, read, write;
    logic [31:0] address, writedata;
    logic [3:0]  byteenable;
    logic [31:0] mem_readdata = 32'h0;

    logic        waitrequest_a [3];
    logic [31:0] readdata_a [3];
    logic        mem_read_a [3];
    logic        mem_write_a [3];
    logic [31:0] mem_address_a [3];
    logic [31:0] mem_writedata_a [3];
    logic [3:0]  mem_byteenable_a [3];
    logic        protocol_error_a [3];
    logic [31:0] read_count_a [3];
    logic [31:0] write_count_a [3];
    logic [31:0] stall_count_a [3];

    int sel = 0;
    logic        waitrequest_s, mem_read_s, mem_write_s, protocol_error_s;
    logic [31:0] readdata_s, mem_address_s, mem_writedata_s;
    logic [31:0] read_count_s, write_count_s, stall_count_s;
    logic [3:0]  mem_byteenable_s;

    assign waitrequest_s    = waitrequest_a[sel];
    assign readdata_s       = readdata_a[sel];
    assign mem_read_s       = mem_read_a[sel];
    assign mem_write_s      = mem_write_a[sel];
    assign mem_address_s    = mem_address_a[sel];
    assign mem_writedata_s  = mem_writedata_a[sel];
    assign mem_byteenable_s = mem_byteenable_a[sel];
    assign protocol_error_s = protocol_error_a[sel];
    assign read_count_s     = read_count_a[sel];
    assign write_count_s    = write_count_a[sel];
    assign stall_count_s    = stall_count_a[sel];

    avalon_wait_injector #(.READ_WAIT(2), .WRITE_WAIT(3), .RANDOM_MODE(0)) u_fix (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest_a[0]),
        .readdata(readdata_a[0]), .mem_read(mem_read_a[0]), .mem_write(mem_write_a[0]),
        .mem_address(mem_address_a[0]), .mem_writedata(mem_writedata_a[0]),
        .mem_byteenable(mem_byteenable_a[0]), .mem_readdata(mem_readdata),
        .protocol_error(protocol_error_a[0]), .read_count(read_count_a[0]),
        .write_count(write_count_a[0]), .stall_count(stall_count_a[0]));

    avalon_wait_injector #(.READ_WAIT(0), .WRITE_WAIT(1), .RANDOM_MODE(0)) u_zero (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest_a[1]),
        .readdata(readdata_a[1]), .mem_read(mem_read_a[1]), .mem_write(mem_write_a[1]),
        .mem_address(mem_address_a[1]), .mem_writedata(mem_writedata_a[1]),
        .mem_byteenable(mem_byteenable_a[1]), .mem_readdata(mem_readdata),
        .protocol_error(protocol_error_a[1]), .read_count(read_count_a[1]),
        .write_count(write_count_a[1]), .stall_count(stall_count_a[1]));

    avalon_wait_injector #(.RANDOM_MODE(1), .MAX_WAIT(7), .LFSR_SEED(8'hA5)) u_rnd (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest_a[2]),
        .readdata(readdata_a[2]), .mem_read(mem_read_a[2]), .mem_write(mem_write_a[2]),
        .mem_address(mem_address_a[2]), .mem_writedata(mem_writedata_a[2]),
        .mem_byteenable(mem_byteenable_a[2]), .mem_readdata(mem_readdata),
        .protocol_error(protocol_error_a[2]), .read_count(read_count_a[2]),
        .write_count(write_count_a[2]), .stall_count(stall_count_a[2]));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_strobes = 0;
    int wr_strobes = 0;
    int last_done_cyc = 0;
    int lfsr_m = 8'hA5;
    int exp_rc, exp_wc, exp_sc;

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2402_0005;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // Single-cycle RAM: data for a strobed address is presented on the following cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read_s) mem_readdata <= ram_f(mem_address_s);
    end

    always @(negedge clk) begin
        if (mem_read_s)  rd_strobes++;
        if (mem_write_s) wr_strobes++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        lfsr_m = 8'hA5;
        exp_rc = 0;
        exp_wc = 0;
        exp_sc = 0;
    endtask

    // Expected wait count W from the latency rules; random mode steps an 8-bit LFSR model.
    task automatic model_wait(input bit is_rd, output int w);
        int fb;
        case (sel)
            0: w = is_rd ? 2 : 3;
            1: w = is_rd ? 0 : 1;
            default: begin
                w      = lfsr_m % 8;
                fb     = $countones(lfsr_m & 8'hB8) % 2;
                lfsr_m = ((lfsr_m * 2) + fb) % 256;
            end
        endcase
    endtask

    // kind: 0 read, 1 write, 2 read and write together. Called at posedge+1.
    task automatic do_txn(input int kind, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int stalls, output int strobe_cyc,
                          output logic [31:0] rd, output logic [31:0] s_addr,
                          output logic [31:0] s_data, output logic [3:0] s_be);
        bit done = 0;
        read = (kind != 1);
        write = (kind != 0);
        address = a;
        writedata = d;
        byteenable = be;
        stalls = 0;
        strobe_cyc = -1;
        rd = '0;
        s_addr = '0;
        s_data = '0;
        s_be = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if ((mem_read_s || mem_write_s) && strobe_cyc < 0) begin
                strobe_cyc = c;
                s_addr = mem_address_s;
                s_data = mem_writedata_s;
                s_be   = mem_byteenable_s;
            end
            if (waitrequest_s) begin
                stalls++;
            end else begin
                done = 1;
                rd = readdata_s;
                last_done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        read = 1'b0;
        write = 1'b0;
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_random(input int n, input bit reads_only);
        int kind, w, st, sc;
        logic [31:0] a, d, rd, sa, sd;
        logic [3:0] be, sb;
        for (int i = 0; i < n; i++) begin
            kind = reads_only ? 0 : int'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            be = 4'($urandom_range(1, 15));
            model_wait(kind == 0, w);
            do_txn(kind, a, d, be, st, sc, rd, sa, sd, sb);
            chk("rnd_stall", st, w + 2);
            chk("rnd_strobe_cyc", sc, w + 1);
            chk("rnd_addr", sa, a);
            if (kind == 0) begin
                chk("rnd_rdata", rd, ram_f(a));
                exp_rc++;
            end else begin
                chk("rnd_wdata", sd, d);
                chk("rnd_be", {28'd0, sb}, {28'd0, be});
                exp_wc++;
            end
            exp_sc += w + 2;
            if (sel == 2) chk("rnd_range", 32'(st >= 2 && st <= 9), 32'd1);
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        int st, sc, r0, w0, t0;
        logic [31:0] rd, sa, sd;
        logic [3:0] sb;

        reset = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_waitreq", 32'(waitrequest_a[k]), 32'd0);
            chk("rst_readdata", readdata_a[k], 32'd0);
            chk("rst_strobes", 32'({mem_read_a[k], mem_write_a[k]}), 32'd0);
            chk("rst_mem_addr", mem_address_a[k], 32'd0);
            chk("rst_perr", 32'(protocol_error_a[k]), 32'd0);
            chk("rst_counts", read_count_a[k] | write_count_a[k] | stall_count_a[k], 32'd0);
        end
        reset = 1'b1;

        // Fixed read, W=2
        sel = 0;
        #1;
        r0 = rd_strobes;
        do_txn(0, 32'hBFC0_0000, 32'h0, 4'hF, st, sc, rd, sa, sd, sb);
        chk("rd_stall", st, 4);
        chk("rd_strobe_cyc", sc, 3);
        chk("rd_data", rd, 32'h2402_0005);
        chk("rd_strobe_cnt", rd_strobes - r0, 1);
        chk("rd_count", read_count_s, 1);
        chk("rd_stall_count", stall_count_s, 4);
        idle(2);
        chk("rd_hold", readdata_s, 32'h2402_0005);

        // Fixed write, W=3
        w0 = wr_strobes;
        do_txn(1, 32'h100, 32'h0000_BEEF, 4'b0011, st, sc, rd, sa, sd, sb);
        chk("wr_stall", st, 5);
        chk("wr_strobe_cyc", sc, 4);
        chk("wr_addr", sa, 32'h100);
        chk("wr_data", sd, 32'h0000_BEEF);
        chk("wr_be", {28'd0, sb}, 32'h3);
        chk("wr_strobe_cnt", wr_strobes - w0, 1);
        chk("wr_count", write_count_s, 1);
        chk("wr_stall_count", stall_count_s, 9);
        chk("wr_rd_hold", readdata_s, 32'h2402_0005);

        // Zero-wait back-to-back reads
        sel = 1;
        do_reset();
        t0 = cyc;
        r0 = rd_strobes;
        do_txn(0, 32'h0, 32'h0, 4'hF, st, sc, rd, sa, sd, sb);
        chk("b2b_done0", last_done_cyc - t0, 2);
        chk("b2b_data0", rd, ram_f(32'h0));
        do_txn(0, 32'h4, 32'h0, 4'hF, st, sc, rd, sa, sd, sb);
        chk("b2b_done1", last_done_cyc - t0, 5);
        chk("b2b_data1", rd, ram_f(32'h4));
        chk("b2b_strobes", rd_strobes - r0, 2);
        chk("b2b_count", read_count_s, 2);

        // Protocol violations on the fixed instance
        sel = 0;
        do_reset();
        r0 = rd_strobes;
        read = 1'b1;
        address = 32'h20;
        idle(2);
        read = 1'b0;
        idle(3);
        chk("drop_wait_strobe", rd_strobes - r0, 0);
        chk("drop_wait_perr", 32'(protocol_error_s), 1);
        chk("drop_wait_rc", read_count_s, 0);
        read = 1'b1;
        idle(3);
        read = 1'b0;
        idle(3);
        chk("drop_issue_strobe", rd_strobes - r0, 1);
        chk("drop_issue_rc", read_count_s, 0);
        chk("drop_issue_waitreq", 32'(waitrequest_s), 0);
        r0 = rd_strobes;
        w0 = wr_strobes;
        do_txn(2, 32'h40, 32'h1234, 4'hF, st, sc, rd, sa, sd, sb);
        chk("both_stall", st, 4);
        chk("both_data", rd, ram_f(32'h40));
        chk("both_rd_strobe", rd_strobes - r0, 1);
        chk("both_wr_strobe", wr_strobes - w0, 0);
        chk("both_counts", {read_count_s[15:0], write_count_s[15:0]}, 32'h0001_0000);
        chk("both_perr", 32'(protocol_error_s), 1);
        do_reset();
        chk("perr_cleared", 32'(protocol_error_s), 0);

        // Random-latency instance: reads only, then a mix
        sel = 2;
        do_reset();
        run_random(16, 1);
        run_random(24, 0);
        chk("rnd_rc", read_count_s, exp_rc);
        chk("rnd_wc", write_count_s, exp_wc);
        chk("rnd_sc", stall_count_s, exp_sc);
        chk("rnd_perr", 32'(protocol_error_s), 0);

        // Fixed instance under random traffic
        sel = 0;
        do_reset();
        run_random(20, 0);
        chk("fix_rc", read_count_s, exp_rc);
        chk("fix_wc", write_count_s, exp_wc);
        chk("fix_sc", stall_count_s, exp_sc);

        // Reset in the middle of a write's wait phase
        w0 = wr_strobes;
        write = 1'b1;
        address = 32'h200;
        writedata = 32'hCAFE_F00D;
        idle(2);
        reset = 1'b0;
        write = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_waitreq", 32'(waitrequest_s), 0);
        chk("mid_rst_wr", 32'(mem_write_s), 0);
        chk("mid_rst_addr", mem_address_s, 32'd0);
        chk("mid_rst_counts", read_count_s | write_count_s | stall_count_s, 32'd0);
        chk("mid_rst_perr", 32'(protocol_error_s), 0);
        chk("mid_rst_rdata", readdata_s, 32'd0);
        reset = 1'b1;
        idle(6);
        chk("mid_rst_no_wr", wr_strobes - w0, 0);
        chk("mid_rst_wc", write_count_s, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_wait_injector.md
Name: avalon_wait_injector

Overview:
Parametrised wait-state injector between the mips_cpu_bus Avalon-style master port and a single-cycle-read RAM model. Replaces ad-hoc delay-driven waitrequest generation with a clocked, synthesizable FSM. Supports independent read/write latencies, an optional pseudo-random latency mode, protocol-violation detection and transaction/stall counters for bench statistics.

Parameters:
ADDR_WIDTH, 32, master/slave address width
DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8
READ_WAIT, 2, fixed extra wait cycles per read (0..255)
WRITE_WAIT, 3, fixed extra wait cycles per write (0..255)
RANDOM_MODE, 0, 0 = fixed waits; 1 = LFSR-derived waits
MAX_WAIT, 7, random-mode upper bound (0..255)
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset
read  input  1  master read request
write  input  1  master write request
address  input  ADDR_WIDTH  master address
writedata  input  DATA_WIDTH  master write data
byteenable  input  DATA_WIDTH/8  master byte lanes
waitrequest  output  1  stall to master (combinational from state and request)
readdata  output  DATA_WIDTH  read data, valid in completion cycle
mem_read  output  1  one-cycle RAM read strobe
mem_write  output  1  one-cycle RAM write strobe
mem_address  output  ADDR_WIDTH  registered address to RAM
mem_writedata  output  DATA_WIDTH  registered write data to RAM
mem_byteenable  output  DATA_WIDTH/8  registered byte lanes to RAM
mem_readdata  input  DATA_WIDTH  RAM data, valid the cycle after mem_read
protocol_error  output  1  sticky violation flag
read_count  output  32  completed reads, wraps
write_count  output  32  completed writes, wraps
stall_count  output  32  cycles with request high and waitrequest high, wraps

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, counters 0, protocol_error 0, mem_read/mem_write 0, mem_* data/address 0, readdata 0, LFSR = LFSR_SEED. Reset mid-transaction aborts it; no strobe after the reset edge.
- waitrequest = (read|write) && state != COMPLETE. Idle with no request: waitrequest 0.
- States: IDLE, WAIT, ISSUE, COMPLETE.
- IDLE: on read or write, latch address/writedata/byteenable/kind into mem_* registers; load wait counter W (fixed: READ_WAIT or WRITE_WAIT; random: LFSR mod (MAX_WAIT+1)); advance LFSR once. Next state WAIT if W>0, else ISSUE.
- read && write together: treated as read, write ignored, protocol_error set.
- WAIT: decrement counter; go to ISSUE when counter reaches 1→0 (exactly W cycles in WAIT).
- ISSUE: mem_read or mem_write high for exactly this cycle; next COMPLETE.
- COMPLETE: waitrequest 0; for reads readdata = mem_readdata sampled this cycle, registered and held until next read completes; increment read_count or write_count; next IDLE.
- Latency: request first seen in cycle 0 completes in cycle W+2; waitrequest high for W+2 cycles.
- Back-to-back: request held after completion is taken as new transaction in the following IDLE cycle (one extra stall cycle).
- Master drops request, or changes address/kind, during WAIT/ISSUE: protocol_error set; in WAIT return to IDLE with no strobe; in ISSUE the strobe already issued completes to RAM, FSM returns to IDLE, no counter increment.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0; never all-zero.
- Counters wrap 0xFFFFFFFF→0 silently.

Test Plan:
- Fixed, READ_WAIT=2: read addr 0xBFC00000 held, RAM returns 0x24020005 -> waitrequest high cycles 0–3, mem_read pulse cycle 3, readdata 0x24020005 in cycle 4, read_count 1, stall_count 4.
- WRITE_WAIT=3: write 0x0000BEEF, byteenable 4'b0011, addr 0x100 -> mem_write single pulse cycle 4 with registered values; completion cycle 5; write_count 1.
- READ_WAIT=0 back-to-back reads of 0x0 and 0x4 -> completions in cycles 2 and 5; two mem_read pulses; read_count 2.
- Master drops read in WAIT -> no mem_read, protocol_error 1 (sticky until reset), read_count unchanged; read&write together -> read performed, protocol_error 1.
- RANDOM_MODE=1, MAX_WAIT=7, seed 0xA5, 16 reads -> every stall length in 2..9 and matching LFSR sequence reference model; LFSR never 0.
- reset low during WAIT of a write -> next edge all outputs at reset values, no mem_write ever asserted, counters 0.
